wb_arbiter: RTL

//  Schedules the single register-file write port among the execution units (ALU, LSU, MUL, DIV).

---
 rtl/wb_arbiter_pkg.sv | 27 ++
 rtl/wb_hold_buf.sv | 50 +++++
 rtl/wb_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
// ============================================================================
// Module   : wb_arbiter_pkg
// Brief    : Shared types and constants for the write-back arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_arbiter_pkg;

    localparam int XLEN         = 32;
    localparam int WB_TAG_WIDTH = 8;
    localparam int N_WB_SRC     = 4;

    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_LSU = 1;
    localparam int WB_SRC_MUL = 2;
    localparam int WB_SRC_DIV = 3;

    typedef struct packed {
        logic [4:0]              rd_addr;
        logic [XLEN-1:0]         data;
        logic [WB_TAG_WIDTH-1:0] tag;
    } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/wb_hold_buf.sv
// ============================================================================
// Module   : wb_hold_buf
// Brief    : One-entry result holding buffer with load, drain and flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_hold_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_flush,
    input  logic         i_load,
    input  logic         i_drain,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Flush wins over a same-cycle load so a result accepted while flushing is dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module   : wb_arbiter
// Brief    : Schedules the register-file write port among ALU/LSU/MUL/DIV.
//            Optional macro WB_ARB_RR_EN: round-robin among LSU/MUL/DIV.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int N_SRC     = N_WB_SRC,
    parameter int TAG_WIDTH = WB_TAG_WIDTH
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            pipe_flush,
    input  logic [N_SRC-1:0]                req_valid,
    output logic [N_SRC-1:0]                req_ready,
    input  logic [N_SRC-1:0][4:0]           req_rd_addr,
    input  logic [N_SRC-1:0][XLEN-1:0]      req_data,
    input  logic [N_SRC-1:0][TAG_WIDTH-1:0] req_tag,
    output logic                            exu_wb_rd_wr_en,
    output logic [4:0]                      exu_wb_rd_addr,
    output logic [XLEN-1:0]                 exu_wb_data,
    output logic [N_SRC-1:0]                wb_pending
);

    localparam int ENTRY_W = 5 + XLEN + TAG_WIDTH;

    logic [N_SRC-1:0]                w_buf_valid;
    logic [N_SRC-1:0]                w_unmasked;
    logic [N_SRC-1:0]                w_elig;
    logic [N_SRC-1:0]                w_grant;
    logic [N_SRC-1:0][4:0]           w_rd;
    logic [N_SRC-1:0][XLEN-1:0]      w_data;
    logic [N_SRC-1:0][TAG_WIDTH-1:0] w_tag;
    logic [TAG_WIDTH-1:0]            w_age_diff;
    logic                            w_found;
    logic [4:0]                      w_sel_rd;
    logic [XLEN-1:0]                 w_sel_data;

    logic                            r_wr_en;
    logic [4:0]                      r_rd_addr;
    logic [XLEN-1:0]                 r_data;

    generate
        for (genvar i = 0; i < N_SRC; i++) begin : g_buf
            logic [ENTRY_W-1:0] w_entry;

            wb_hold_buf #(.W(ENTRY_W)) u_hold_buf (
                .clk     (clk),
                .rstn    (rstn),
                .i_flush (pipe_flush),
                .i_load  (req_valid[i] & req_ready[i]),
                .i_drain (w_grant[i]),
                .i_data  ({req_rd_addr[i], req_data[i], req_tag[i]}),
                .o_valid (w_buf_valid[i]),
                .o_data  (w_entry)
            );

            assign {w_rd[i], w_data[i], w_tag[i]} = w_entry;
        end
    endgenerate

    assign req_ready  = ~w_buf_valid | w_grant;
    assign wb_pending = w_buf_valid;

    // Hold back any entry that has an older pending write to the same rd (WAW order).
    always_comb begin
        w_unmasked = w_buf_valid;
        w_age_diff = '0;
        for (int i = 0; i < N_SRC; i++) begin
            for (int j = 0; j < N_SRC; j++) begin
                if ((i != j) && w_buf_valid[i] && w_buf_valid[j] && (w_rd[i] == w_rd[j])) begin
                    w_age_diff = w_tag[j] - w_tag[i];
                    if (w_age_diff[TAG_WIDTH-1]) begin
                        w_unmasked[i] = 1'b0;
                    end
                end
            end
        end
        w_elig = (|w_unmasked) ? w_unmasked : w_buf_valid;
    end

`ifdef WB_ARB_RR_EN
    localparam int PTR_W = $clog2(N_SRC);

    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] w_next_ptr;

    // ALU is absolute; the rest are searched from r_rr_ptr upward, then wrap to LSU.
    always_comb begin
        w_grant    = '0;
        w_found    = 1'b0;
        w_next_ptr = r_rr_ptr;
        if (w_elig[WB_SRC_ALU]) begin
            w_grant[WB_SRC_ALU] = 1'b1;
            w_found             = 1'b1;
        end
        for (int j = 1; j < N_SRC; j++) begin
            if (!w_found && w_elig[j] && (j >= int'(r_rr_ptr))) begin
                w_grant[j] = 1'b1;
                w_found    = 1'b1;
                w_next_ptr = (j == N_SRC - 1) ? PTR_W'(WB_SRC_LSU) : PTR_W'(j + 1);
            end
        end
        for (int j = 1; j < N_SRC; j++) begin
            if (!w_found && w_elig[j] && (j < int'(r_rr_ptr))) begin
                w_grant[j] = 1'b1;
                w_found    = 1'b1;
                w_next_ptr = (j == N_SRC - 1) ? PTR_W'(WB_SRC_LSU) : PTR_W'(j + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr <= PTR_W'(WB_SRC_LSU);
        end else if ((|w_grant) && !w_grant[WB_SRC_ALU]) begin
            r_rr_ptr <= w_next_ptr;
        end
    end
`else
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        for (int j = 0; j < N_SRC; j++) begin
            if (!w_found && w_elig[j]) begin
                w_grant[j] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int j = 0; j < N_SRC; j++) begin
            if (w_grant[j]) begin
                w_sel_rd   = w_rd[j];
                w_sel_data = w_data[j];
            end
        end
    end

    // x0 results still drain; only the write strobe is suppressed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_en   <= 1'b0;
            r_rd_addr <= '0;
            r_data    <= '0;
        end else begin
            r_wr_en <= (|w_grant) && !pipe_flush && (w_sel_rd != 5'd0);
            if ((|w_grant) && !pipe_flush) begin
                r_rd_addr <= w_sel_rd;
                r_data    <= w_sel_data;
            end
        end
    end

    assign exu_wb_rd_wr_en = r_wr_en;
    assign exu_wb_rd_addr  = r_rd_addr;
    assign exu_wb_data     = r_data;

endmodule

`default_nettype wire
